// File: rtl/chunked_serial_adder.sv
// ---------------------------------------------------------------------------
// chunked_serial_adder
//
// Multi-cycle N-bit adder/subtractor. Operands are captured through a
// valid/ready handshake. The block then adds one CHUNK-bit slice per clock,
// keeping the inter-slice carry in a flop. The result is presented through a
// second valid/ready handshake.
//
// Optional feature macro: CHUNKED_SERIAL_ADDER_OVF_EN
//   When defined, the block adds output port ovf: the two's-complement signed
//   overflow of the last operation, registered together with Cout.
//
// Parameters:
//   N      operand/result width (N >= 1)
//   CHUNK  bits added per cycle (1 <= CHUNK <= N, N % CHUNK == 0)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous reset, active-low
//   in_valid   operand pair valid
//   in_ready   block can accept operands (IDLE and not in reset)
//   A, B       operands
//   Cin        carry-in, add mode only
//   sub        0 = A + B + Cin, 1 = A - B
//   out_valid  result valid
//   out_ready  downstream accepts result
//   Sum        registered result
//   Cout       final carry-out; in subtract mode 1 = no borrow
//   ovf        signed overflow (only with CHUNKED_SERIAL_ADDER_OVF_EN)
// ---------------------------------------------------------------------------
module chunked_serial_adder #(
    parameter int N     = 8,
    parameter int CHUNK = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] Sum,
    output logic         Cout
`ifdef CHUNKED_SERIAL_ADDER_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int NSLICE = N / CHUNK;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    // Reject illegal slicing at elaboration time.
    if ((N < 1) || (CHUNK < 1) || (CHUNK > N) || ((N % CHUNK) != 0)) begin : g_param_check
        $error("chunked_serial_adder: illegal N/CHUNK combination");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            next_state_s;
    logic [N-1:0]      opa_r;
    logic [N-1:0]      opb_r;
    logic              carry_r;
    logic [IDXW-1:0]   idx_r;
    logic [N-1:0]      sum_r;
    logic              cout_r;
    logic              out_valid_r;
    logic [CHUNK-1:0]  a_slice_s;
    logic [CHUNK-1:0]  b_slice_s;
    logic [CHUNK:0]    slice_add_s;
    logic              last_slice_s;
`ifdef CHUNKED_SERIAL_ADDER_OVF_EN
    logic              ovf_r;
    logic              slice_ovf_s;
`endif

    // Select the current slice and form its CHUNK-bit sum with carry-out.
    always_comb begin
        a_slice_s    = opa_r[idx_r*CHUNK +: CHUNK];
        b_slice_s    = opb_r[idx_r*CHUNK +: CHUNK];
        slice_add_s  = {1'b0, a_slice_s} + {1'b0, b_slice_s} + {{CHUNK{1'b0}}, carry_r};
        last_slice_s = (idx_r == LAST_IDX);
    end

`ifdef CHUNKED_SERIAL_ADDER_OVF_EN
    // Carry into the MSB equals a ^ b ^ s at that bit; overflow is it XOR carry-out.
    always_comb begin
        slice_ovf_s = a_slice_s[CHUNK-1] ^ b_slice_s[CHUNK-1]
                    ^ slice_add_s[CHUNK-1] ^ slice_add_s[CHUNK];
    end
`endif

    // Next-state logic for the IDLE -> BUSY -> DONE sequence.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    next_state_s = BUSY;
                end else begin
                    next_state_s = IDLE;
                end
            end
            BUSY: begin
                if (last_slice_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = BUSY;
                end
            end
            DONE: begin
                if (out_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = DONE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register and datapath: capture, per-slice accumulate, retire.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            opa_r       <= {N{1'b0}};
            opb_r       <= {N{1'b0}};
            carry_r     <= 1'b0;
            idx_r       <= {IDXW{1'b0}};
            sum_r       <= {N{1'b0}};
            cout_r      <= 1'b0;
            out_valid_r <= 1'b0;
`ifdef CHUNKED_SERIAL_ADDER_OVF_EN
            ovf_r       <= 1'b0;
`endif
        end else begin
            state_r <= next_state_s;
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        opa_r   <= A;
                        // Subtraction as A + ~B + 1.
                        opb_r   <= sub ? ~B : B;
                        carry_r <= sub ? 1'b1 : Cin;
                        idx_r   <= {IDXW{1'b0}};
                    end
                end
                BUSY: begin
                    sum_r[idx_r*CHUNK +: CHUNK] <= slice_add_s[CHUNK-1:0];
                    carry_r                     <= slice_add_s[CHUNK];
                    idx_r                       <= idx_r + IDXW'(1);
                    if (last_slice_s) begin
                        cout_r      <= slice_add_s[CHUNK];
                        out_valid_r <= 1'b1;
`ifdef CHUNKED_SERIAL_ADDER_OVF_EN
                        ovf_r       <= slice_ovf_s;
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (state_r == IDLE) && rst_n;
    assign out_valid = out_valid_r;
    assign Sum       = sum_r;
    assign Cout      = cout_r;
`ifdef CHUNKED_SERIAL_ADDER_OVF_EN
    assign ovf       = ovf_r;
`endif

endmodule
